// File: rtl/ex_muldiv_if.sv
// Request/result bundle between the EX stage and the multiply/divide unit.
// The master drives the request; the slave (the MDU) returns busy and HI/LO.
interface ex_muldiv_if;
  logic        start;
  logic [3:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (output start, op, src_a, src_b, input busy, hi, lo);
  modport slave  (input start, op, src_a, src_b, output busy, hi, lo);
endinterface

// File: rtl/ex_muldiv.sv
// Multi-cycle EX-stage multiply/divide unit owning the architectural HI/LO registers.
// Define MDU_MADD_EN to add MADD/MADDU (accumulate product into {HI,LO}).
module ex_muldiv #(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10
) (
  input logic        CLK,
  input logic        reset,
  ex_muldiv_if.slave bus
);

  localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
  localparam logic [CNT_W-1:0] MULT_CNT = CNT_W'(MULT_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_CNT  = CNT_W'(DIV_LAT - 1);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MADD  = 4'd8;
`ifdef MDU_MADD_EN
  localparam logic [3:0] OP_MADDU = 4'd9;
`endif

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [63:0]      pend_q, pend_d;
  logic             wr_q, wr_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;

  logic        op_signed, neg_a, neg_b;
  logic [63:0] ext_a, ext_b, prod;
  logic [31:0] mag_a, mag_b, div_b, uq, ur, quo, rmd;

  // Divide on magnitudes so 0x80000000 / -1 wraps to 0x80000000 instead of overflowing.
  always_comb begin
    op_signed = (bus.op == OP_MULT) || (bus.op == OP_DIV) || (bus.op == OP_MADD);
    ext_a     = op_signed ? {{32{bus.src_a[31]}}, bus.src_a} : {32'h0, bus.src_a};
    ext_b     = op_signed ? {{32{bus.src_b[31]}}, bus.src_b} : {32'h0, bus.src_b};
    prod      = ext_a * ext_b;
    neg_a     = op_signed && bus.src_a[31];
    neg_b     = op_signed && bus.src_b[31];
    mag_a     = neg_a ? (32'h0 - bus.src_a) : bus.src_a;
    mag_b     = neg_b ? (32'h0 - bus.src_b) : bus.src_b;
    div_b     = (mag_b == 32'h0) ? 32'd1 : mag_b;
    uq        = mag_a / div_b;
    ur        = mag_a % div_b;
    quo       = (neg_a ^ neg_b) ? (32'h0 - uq) : uq;
    rmd       = neg_a ? (32'h0 - ur) : ur;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    wr_d    = wr_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          case (bus.op)
            OP_MULT, OP_MULTU: begin
              pend_d  = prod;
              wr_d    = 1'b1;
              cnt_d   = MULT_CNT;
              state_d = S_RUN;
            end
            // A zero divisor still occupies the unit but never commits.
            OP_DIV, OP_DIVU: begin
              pend_d  = {rmd, quo};
              wr_d    = (mag_b != 32'h0);
              cnt_d   = DIV_CNT;
              state_d = S_RUN;
            end
`ifdef MDU_MADD_EN
            OP_MADD, OP_MADDU: begin
              pend_d  = {hi_q, lo_q} + prod;
              wr_d    = 1'b1;
              cnt_d   = MULT_CNT;
              state_d = S_RUN;
            end
`endif
            OP_MTHI: hi_d = bus.src_a;
            OP_MTLO: lo_d = bus.src_a;
            default: ;
          endcase
        end
      end
      S_RUN: begin
        if (cnt_q == '0) begin
          if (wr_q) {hi_d, lo_d} = pend_q;
          wr_d    = 1'b0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      pend_q  <= '0;
      wr_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      wr_q    <= wr_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign bus.busy = (state_q == S_RUN);
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Self-checking bench for ex_muldiv: directed cases then randomized traffic
// compared each cycle against an arithmetic reference model.
module tb_ex_muldiv;

  localparam int MULT_LAT = 5;
  localparam int DIV_LAT  = 10;

  logic clk;
  logic reset;
  ex_muldiv_if bus ();

  ex_muldiv #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT)) dut (
    .CLK  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model: remaining busy cycles plus the result to commit.
  logic [31:0] m_hi, m_lo;
  logic [63:0] m_pend;
  logic        m_wr;
  int          m_rem;

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_step(input logic rst, input logic s, input logic [3:0] o,
                            input logic [31:0] a, input logic [31:0] b);
    longint sq, sr;
    if (rst) begin
      m_hi = 0; m_lo = 0; m_pend = 0; m_wr = 0; m_rem = 0;
    end else if (m_rem > 0) begin
      m_rem--;
      if (m_rem == 0 && m_wr) {m_hi, m_lo} = m_pend;
    end else if (s) begin
      case (o)
        4'd1: begin m_pend = longint'($signed(a)) * longint'($signed(b)); m_wr = 1; m_rem = MULT_LAT; end
        4'd2: begin m_pend = {32'h0, a} * {32'h0, b}; m_wr = 1; m_rem = MULT_LAT; end
        4'd3: begin
          m_rem = DIV_LAT;
          m_wr  = (b != 0);
          if (b != 0) begin
            sq = longint'($signed(a)) / longint'($signed(b));
            sr = longint'($signed(a)) % longint'($signed(b));
            m_pend = {sr[31:0], sq[31:0]};
          end
        end
        4'd4: begin
          m_rem = DIV_LAT;
          m_wr  = (b != 0);
          if (b != 0) m_pend = {a % b, a / b};
        end
        4'd5: m_hi = a;
        4'd6: m_lo = a;
`ifdef MDU_MADD_EN
        4'd8: begin m_pend = {m_hi, m_lo} + 64'(longint'($signed(a)) * longint'($signed(b))); m_wr = 1; m_rem = MULT_LAT; end
        4'd9: begin m_pend = {m_hi, m_lo} + {32'h0, a} * {32'h0, b}; m_wr = 1; m_rem = MULT_LAT; end
`endif
        default: ;
      endcase
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic s, input logic [3:0] o,
                               input logic [31:0] a, input logic [31:0] b);
    reset     = rst;
    bus.start = s;
    bus.op    = o;
    bus.src_a = a;
    bus.src_b = b;
    @(posedge clk);
    model_step(rst, s, o, a, b);
    #1;
    checkOutput("busy", {31'h0, bus.busy}, {31'h0, (m_rem > 0)});
    checkOutput("hi", bus.hi, m_hi);
    checkOutput("lo", bus.lo, m_lo);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 4'd0, 32'h0, 32'h0);
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int busy_cycles;
    reset = 1'b1; bus.start = 1'b0; bus.op = 4'd0; bus.src_a = 0; bus.src_b = 0;
    m_hi = 0; m_lo = 0; m_pend = 0; m_wr = 0; m_rem = 0;

    applyStimulus(1'b1, 1'b0, 4'd0, 32'h0, 32'h0);
    applyStimulus(1'b1, 1'b0, 4'd0, 32'h0, 32'h0);
    checkOutput("reset_busy", {31'h0, bus.busy}, 32'h0);
    checkOutput("reset_hi", bus.hi, 32'h0);
    checkOutput("reset_lo", bus.lo, 32'h0);

    // MULT -2 * 3, measuring how long busy stays high.
    applyStimulus(1'b0, 1'b1, 4'd1, 32'hFFFF_FFFE, 32'd3);
    busy_cycles = 0;
    for (int i = 0; i < 12; i++) begin
      if (bus.busy) busy_cycles++;
      applyStimulus(1'b0, 1'b0, 4'd0, 32'h0, 32'h0);
    end
    checkOutput("mult_busy_len", busy_cycles, MULT_LAT);
    checkOutput("mult_hi", bus.hi, 32'hFFFF_FFFF);
    checkOutput("mult_lo", bus.lo, 32'hFFFF_FFFA);

    applyStimulus(1'b0, 1'b1, 4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    idle(MULT_LAT);
    checkOutput("multu_hi", bus.hi, 32'hFFFF_FFFE);
    checkOutput("multu_lo", bus.lo, 32'h0000_0001);

    applyStimulus(1'b0, 1'b1, 4'd3, 32'hFFFF_FFF9, 32'd2);
    idle(DIV_LAT);
    checkOutput("div_hi", bus.hi, 32'hFFFF_FFFF);
    checkOutput("div_lo", bus.lo, 32'hFFFF_FFFD);

    applyStimulus(1'b0, 1'b1, 4'd4, 32'd7, 32'd0);
    busy_cycles = 0;
    for (int i = 0; i < DIV_LAT + 2; i++) begin
      if (bus.busy) busy_cycles++;
      applyStimulus(1'b0, 1'b0, 4'd0, 32'h0, 32'h0);
    end
    checkOutput("div0_busy_len", busy_cycles, DIV_LAT);
    checkOutput("div0_hi", bus.hi, 32'hFFFF_FFFF);
    checkOutput("div0_lo", bus.lo, 32'hFFFF_FFFD);

    applyStimulus(1'b0, 1'b1, 4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    idle(DIV_LAT);
    checkOutput("divovf_hi", bus.hi, 32'h0);
    checkOutput("divovf_lo", bus.lo, 32'h8000_0000);

    // MULT pulsed mid-DIV, then a start on the very edge busy falls.
    applyStimulus(1'b0, 1'b1, 4'd4, 32'd100, 32'd7);
    idle(3);
    applyStimulus(1'b0, 1'b1, 4'd1, 32'd2, 32'd2);
    idle(DIV_LAT - 5);
    applyStimulus(1'b0, 1'b1, 4'd5, 32'hDEAD_BEEF, 32'h0);
    checkOutput("ignored_hi", bus.hi, 32'd2);
    checkOutput("ignored_lo", bus.lo, 32'd14);
    idle(2);

    // Reset four cycles into a DIV.
    applyStimulus(1'b0, 1'b1, 4'd3, 32'd50, 32'd3);
    idle(3);
    applyStimulus(1'b1, 1'b0, 4'd0, 32'h0, 32'h0);
    checkOutput("abort_busy", {31'h0, bus.busy}, 32'h0);
    checkOutput("abort_hi", bus.hi, 32'h0);
    checkOutput("abort_lo", bus.lo, 32'h0);
    idle(DIV_LAT);

    applyStimulus(1'b0, 1'b1, 4'd5, 32'h1234_5678, 32'h0);
    checkOutput("mthi_hi", bus.hi, 32'h1234_5678);
    applyStimulus(1'b0, 1'b1, 4'd6, 32'h9ABC_DEF0, 32'h0);
    checkOutput("mtlo_lo", bus.lo, 32'h9ABC_DEF0);
    checkOutput("mt_busy", {31'h0, bus.busy}, 32'h0);

    applyStimulus(1'b0, 1'b1, 4'd5, 32'h0, 32'h0);
    applyStimulus(1'b0, 1'b1, 4'd6, 32'hFFFF_FFFF, 32'h0);
    applyStimulus(1'b0, 1'b1, 4'd9, 32'd1, 32'd1);
    idle(MULT_LAT);
`ifdef MDU_MADD_EN
    checkOutput("maddu_hi", bus.hi, 32'h1);
    checkOutput("maddu_lo", bus.lo, 32'h0);
`else
    checkOutput("madd_off_hi", bus.hi, 32'h0);
    checkOutput("madd_off_lo", bus.lo, 32'hFFFF_FFFF);
`endif
    applyStimulus(1'b0, 1'b1, 4'd8, 32'd3, 32'd4);
`ifndef MDU_MADD_EN
    checkOutput("op8_busy", {31'h0, bus.busy}, 32'h0);
`endif
    idle(MULT_LAT);

    for (int i = 0; i < 4000; i++) begin
      applyStimulus(($urandom_range(0, 299) == 0), ($urandom_range(0, 2) == 0),
                    4'($urandom_range(0, 15)), pick_operand(), pick_operand());
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
